// File: rtl/width_converter_n_to_m.sv
// width_converter_n_to_m: splits InWidth-bit words into OutWidth-bit beats
// with partial last words, selectable beat order and synchronous flush.
module width_converter_n_to_m #(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned OutWidth = 8,
  parameter bit          MsbFirst = 1'b0,
  localparam int unsigned Beats = InWidth / OutWidth,
  localparam int unsigned CntW  = $clog2(Beats) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sink_valid_i,
  output logic                sink_ready_o,
  input  logic [InWidth-1:0]  sink_data_i,
  input  logic                sink_last_i,
  input  logic [CntW-1:0]     sink_beats_i,
  output logic                source_valid_o,
  input  logic                source_ready_i,
  output logic [OutWidth-1:0] source_data_o,
  output logic                source_last_o,
  input  logic                source_flush_i,
  output logic                busy_o
);

  if (OutWidth == 0 || (OutWidth % 8) != 0 ||
      InWidth < OutWidth || (InWidth % OutWidth) != 0) begin : g_bad_width
    $error("width_converter_n_to_m: illegal InWidth/OutWidth");
  end

  localparam logic [CntW-1:0] BeatsCnt = CntW'(Beats);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [InWidth-1:0] sreg_q, sreg_d;
  logic               last_q, last_d;
  logic [InWidth-1:0] sreg_shift;
  logic [CntW-1:0]    load_cnt;
  logic               accept;
  logic               xfer;

  assign source_valid_o = (cnt_q != '0);
  assign busy_o         = source_valid_o;
  assign source_last_o  = last_q & (cnt_q == OneCnt);

  // Ready looks through to source_ready_i so a new word can replace the
  // final beat in the same cycle and keep the output gap-free.
  assign sink_ready_o = !source_flush_i &
                        ((cnt_q == '0) |
                         ((cnt_q == OneCnt) & source_ready_i));

  assign accept = sink_valid_i & sink_ready_o;
  assign xfer   = source_valid_o & source_ready_i;

  if (MsbFirst) begin : g_msb
    assign source_data_o = sreg_q[InWidth-1 -: OutWidth];
    assign sreg_shift    = sreg_q << OutWidth;
  end else begin : g_lsb
    assign source_data_o = sreg_q[OutWidth-1:0];
    assign sreg_shift    = sreg_q >> OutWidth;
  end

  // Out-of-range beat counts fall back to a full word.
  always_comb begin
    load_cnt = BeatsCnt;
    if (sink_last_i && sink_beats_i != '0 &&
        sink_beats_i <= BeatsCnt) begin
      load_cnt = sink_beats_i;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    sreg_d = sreg_q;
    last_d = last_q;
    if (source_flush_i) begin
      cnt_d  = '0;
      sreg_d = '0;
      last_d = 1'b0;
    end else if (accept) begin
      cnt_d  = load_cnt;
      sreg_d = sink_data_i;
      last_d = sink_last_i;
    end else if (xfer) begin
      cnt_d  = cnt_q - OneCnt;
      sreg_d = sreg_shift;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sreg_q <= sreg_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_width_converter_n_to_m.sv
// tb_width_converter_n_to_m: directed and random checks of two converter
// instances (32->8 LSB-first, 32->16 MSB-first) against a beat-queue model.
module tb_width_converter_n_to_m;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        v0, rdy0, l0, sv0, sr0, sl0, fl0, busy0;
  logic [31:0] d0;
  logic [2:0]  b0;
  logic [7:0]  sd0;

  logic        v1, rdy1, l1, sv1, sr1, sl1, fl1, busy1;
  logic [31:0] d1;
  logic [1:0]  b1;
  logic [15:0] sd1;

  width_converter_n_to_m #(
    .InWidth(32), .OutWidth(8), .MsbFirst(1'b0)
  ) u_lsb (
    .clk_i(clk), .rst_ni(rst_ni),
    .sink_valid_i(v0), .sink_ready_o(rdy0),
    .sink_data_i(d0), .sink_last_i(l0), .sink_beats_i(b0),
    .source_valid_o(sv0), .source_ready_i(sr0),
    .source_data_o(sd0), .source_last_o(sl0),
    .source_flush_i(fl0), .busy_o(busy0)
  );

  width_converter_n_to_m #(
    .InWidth(32), .OutWidth(16), .MsbFirst(1'b1)
  ) u_msb (
    .clk_i(clk), .rst_ni(rst_ni),
    .sink_valid_i(v1), .sink_ready_o(rdy1),
    .sink_data_i(d1), .sink_last_i(l1), .sink_beats_i(b1),
    .source_valid_o(sv1), .source_ready_i(sr1),
    .source_data_o(sd1), .source_last_o(sl1),
    .source_flush_i(fl1), .busy_o(busy1)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit acc0, acc1;

  // Model: each entry is {last, data16} of a beat still to be emitted.
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  function automatic int nbeats(input int full, input bit last, input int b);
    if (!last || b == 0 || b > full) return full;
    return b;
  endfunction

  function automatic void load0(input logic [31:0] w, input bit last,
                                input int b);
    int n;
    n = nbeats(4, last, b);
    q0.delete();
    for (int k = 0; k < n; k++)
      q0.push_back({last && (k == n - 1), 8'h00, w[k*8 +: 8]});
  endfunction

  function automatic void load1(input logic [31:0] w, input bit last,
                                input int b);
    int n;
    n = nbeats(2, last, b);
    q1.delete();
    for (int k = 0; k < n; k++)
      q1.push_back({last && (k == n - 1), w[31 - k*16 -: 16]});
  endfunction

  task automatic step(input string tag);
    bit er0, er1, xf0, xf1, ca0, ca1;
    logic [31:0] cd0, cd1;
    bit cl0, cl1;
    int cb0, cb1;
    #1;
    er0 = !fl0 && (q0.size() == 0 || (q0.size() == 1 && sr0));
    er1 = !fl1 && (q1.size() == 0 || (q1.size() == 1 && sr1));
    chk(tag, "rdy0", rdy0, er0);
    chk(tag, "val0", sv0, q0.size() != 0);
    chk(tag, "busy0", busy0, q0.size() != 0);
    if (q0.size() != 0) begin
      chk(tag, "dat0", sd0, q0[0][15:0]);
      chk(tag, "lst0", sl0, q0[0][16]);
    end else chk(tag, "lst0", sl0, 0);
    chk(tag, "rdy1", rdy1, er1);
    chk(tag, "val1", sv1, q1.size() != 0);
    chk(tag, "busy1", busy1, q1.size() != 0);
    if (q1.size() != 0) begin
      chk(tag, "dat1", sd1, q1[0][15:0]);
      chk(tag, "lst1", sl1, q1[0][16]);
    end else chk(tag, "lst1", sl1, 0);
    ca0 = v0 && er0; ca1 = v1 && er1;
    xf0 = q0.size() != 0 && sr0;
    xf1 = q1.size() != 0 && sr1;
    cd0 = d0; cl0 = l0; cb0 = int'(b0);
    cd1 = d1; cl1 = l1; cb1 = int'(b1);
    acc0 = ca0 && rst_ni; acc1 = ca1 && rst_ni;
    @(posedge clk);
    if (!rst_ni || fl0) q0.delete();
    else if (ca0) load0(cd0, cl0, cb0);
    else if (xf0) void'(q0.pop_front());
    if (!rst_ni || fl1) q1.delete();
    else if (ca1) load1(cd1, cl1, cb1);
    else if (xf1) void'(q1.pop_front());
    #1;
  endtask

  task automatic send0(input logic [31:0] w, input bit last, input int b,
                       input string tag);
    int g;
    g = 0;
    v0 = 1'b1; d0 = w; l0 = last; b0 = 3'(b);
    do begin step(tag); g++; end while (!acc0 && g < 40);
    v0 = 1'b0;
    n_cmp++;
    assert (acc0) else begin
      n_err++;
      $error("FAIL %s/accept0: observed no accept expected accept", tag);
    end
  endtask

  task automatic send1(input logic [31:0] w, input bit last, input int b,
                       input string tag);
    int g;
    g = 0;
    v1 = 1'b1; d1 = w; l1 = last; b1 = 2'(b);
    do begin step(tag); g++; end while (!acc1 && g < 40);
    v1 = 1'b0;
    n_cmp++;
    assert (acc1) else begin
      n_err++;
      $error("FAIL %s/accept1: observed no accept expected accept", tag);
    end
  endtask

  task automatic drain(input int n, input string tag);
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    v0 = 0; d0 = 0; l0 = 0; b0 = 0; sr0 = 1; fl0 = 0;
    v1 = 0; d1 = 0; l1 = 0; b1 = 0; sr1 = 1; fl1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    chk("reset", "dat0", sd0, 0);
    chk("reset", "dat1", sd1, 0);
    step("reset");

    send0(32'h44332211, 1'b0, 0, "stream");
    send0(32'h88776655, 1'b1, 4, "stream");
    drain(6, "stream");

    send0(32'hDDCCBBAA, 1'b1, 2, "part2");
    drain(4, "part2");
    send0(32'hDDCCBBAA, 1'b1, 0, "part0");
    drain(6, "part0");

    send1(32'hA1B2C3D4, 1'b1, 2, "msb2");
    drain(3, "msb2");
    send1(32'hA1B2C3D4, 1'b1, 1, "msb1");
    drain(3, "msb1");

    send0(32'h04030201, 1'b0, 0, "bp");
    step("bp");
    sr0 = 1'b0;
    repeat (3) step("bp_hold");
    sr0 = 1'b1;
    drain(4, "bp");

    send0(32'hCAFEBABE, 1'b0, 0, "flush");
    step("flush");
    fl0 = 1'b1; v0 = 1'b1; d0 = 32'h12345678; l0 = 1'b0;
    step("flush_cyc");
    fl0 = 1'b0;
    send0(32'h12345678, 1'b0, 0, "post_flush");
    drain(5, "post_flush");

    send0(32'h55AA33CC, 1'b0, 0, "rst_mid");
    send1(32'h0BADF00D, 1'b0, 0, "rst_mid");
    step("rst_mid");
    rst_ni = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("rst_mid", "dat0", sd0, 0);
    chk("rst_mid", "dat1", sd1, 0);
    repeat (2) step("rst_hold");
    rst_ni = 1'b1;
    send0(32'h9ABCDEF0, 1'b1, 4, "after_rst");
    send1(32'h13579BDF, 1'b1, 0, "after_rst");
    drain(6, "after_rst");

    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      d0 = $urandom;
      l0 = 1'($urandom_range(0, 1));
      b0 = 3'($urandom_range(0, 7));
      sr0 = ($urandom_range(0, 3) != 0);
      fl0 = ($urandom_range(0, 19) == 0);
      v1 = ($urandom_range(0, 3) != 0);
      d1 = $urandom;
      l1 = 1'($urandom_range(0, 1));
      b1 = 2'($urandom_range(0, 3));
      sr1 = ($urandom_range(0, 3) != 0);
      fl1 = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    fl0 = 0; fl1 = 0; sr0 = 1; sr1 = 1;
    drain(8, "rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/width_converter_n_to_m.md
# width_converter_n_to_m

Parametrised down-converter from an InWidth-bit word stream to an OutWidth-bit beat stream, with selectable beat order. It supports partial final words (beat count supplied with `last`), a `last` marker on the output and a synchronous flush. Zero-bubble throughput holds across word boundaries. It sits between the TTI TX queue and the I3C target FSM, and is also used for wider target-side serialisers (e.g. 32→16).

## Interface
- InWidth, 32, sink word width; must be a multiple of OutWidth.
- OutWidth, 8, source beat width; must be a multiple of 8.
- MsbFirst, 0, 0: emit bits [OutWidth-1:0] first; 1: emit the most-significant beat first.
- Derived: Beats = InWidth/OutWidth (≥1); CntW = $clog2(Beats)+1.
- Elaboration error if either width rule is violated.

- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- sink_valid_i  input  1  word valid
- sink_ready_o  output  1  converter can accept a word this cycle
- sink_data_i  input  InWidth  word data
- sink_last_i  input  1  word is the final word of a transfer
- sink_beats_i  input  CntW  number of valid beats in a last word, 1..Beats; ignored when sink_last_i=0
- source_valid_o  output  1  beat valid
- source_ready_i  input  1  downstream accepts beat
- source_data_o  output  OutWidth  current beat
- source_last_o  output  1  current beat is the final beat of a last word
- source_flush_i  input  1  synchronous discard of held data
- busy_o  output  1  beats remain (equal to source_valid_o)

## Operation
- State: beat counter cnt (CntW bits), shift register sreg (InWidth), flag last_q.
- Word accept: sink_valid_i & sink_ready_o.
  - cnt ← Beats for a non-last word.
  - For a last word, cnt ← sink_beats_i. A value of 0 or greater than Beats is treated as Beats.
  - sreg ← sink_data_i; last_q ← sink_last_i.
- Beat transfer: source_valid_o & source_ready_i.
  - cnt ← cnt−1.
  - sreg shifts by OutWidth: right when MsbFirst=0, left when MsbFirst=1. Vacated bits are filled with 0.
- When a beat transfer and a word accept occur in the same cycle (cnt==1), the accept takes priority: load the new word and drop no beat.
- source_valid_o = (cnt != 0).
- source_data_o = sreg[OutWidth-1:0] when MsbFirst=0; sreg[InWidth-1 -: OutWidth] when MsbFirst=1.
- source_last_o = last_q & (cnt == 1).
- sink_ready_o = !source_flush_i & ((cnt == 0) | ((cnt == 1) & source_ready_i)). This is a combinational path from source_ready_i to sink_ready_o.
- For a partial last word in LSB-first mode, the valid beats are the low-order ones. In MsbFirst mode they are the high-order ones. Unused beats are never emitted.
- Flush (source_flush_i=1): next cycle cnt=0, sreg=0, last_q=0.
  - sink_ready_o is forced low in the flush cycle, so no word is accepted.
  - A beat handshake in the flush cycle still counts as transferred downstream; its state effect is overridden by the flush.

## Timing
- Reset values: cnt=0, sreg=0, last_q=0. Outputs after reset: source_valid_o=0, source_data_o=0, source_last_o=0, busy_o=0, sink_ready_o=1 (absent flush).
- Latency: word accepted at edge T; its first beat is on source_data_o in cycle T+1.
- With source_ready_i held high and sink_valid_i held high, the output carries one beat every cycle with no bubble between words. A full word takes Beats cycles; a last word takes sink_beats_i cycles.
- Backpressure: while source_ready_i=0, source_data_o, source_valid_o and source_last_o stay stable, and sink_ready_o=0 if cnt≠0.
- Flush at cycle T: source_valid_o=0 from T+1. A new word can be accepted from T+1.
- Reset asserted mid-word: all state clears asynchronously; no beat of the partial word appears after reset release.
- Beats=1 (InWidth==OutWidth): the block behaves as a one-entry pipeline register. It keeps full throughput via the cnt==1 accept path.

## Test plan
- 32→8, LSB-first: send 0x44332211 (non-last), then 0x88776655 (last, beats=4), with ready held high. Required: output 11,22,33,44,55,66,77,88 on 8 consecutive cycles; last only on 88; sink_ready pulses on the cycles showing 44 and 88.
- 32→8, partial: send 0xDDCCBBAA with last and beats=2. Required: output AA then BB with last; cnt returns to 0; CC and DD are never emitted. Repeat with beats=0: all 4 beats, last on DD.
- 32→16, MsbFirst=1: send 0xA1B2C3D4 with last and beats=2. Required: output A1B2 then C3D4 with last. Repeat with beats=1: only A1B2, with last.
- Backpressure: 32→8, deassert source_ready_i for 3 cycles after the 2nd beat of 0x04030201. Required: 02 held stable with valid=1 and sink_ready=0 throughout; then 02,03,04 resume.
- Flush: assert source_flush_i for 1 cycle after beat 1 of 0xCAFEBABE while sink_valid_i=1 with 0x12345678. Required: sink_ready=0 during the flush cycle; source_valid=0 the next cycle; 0x12345678 is accepted the cycle after and emits 78,56,34,12.
- Reset: assert rst_ni low mid-word, hold 2 cycles, release. Required: all outputs 0, sink_ready=1; the next word emits from its first beat.
